// File: rtl/adder_pg_stage.sv
// rtl/adder_pg_stage.sv - generate/propagate front stage of a prefix adder with a 2-entry skid buffer
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

module adder_pg_stage #(
  parameter int LEN = `LEN_DATA
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic           sub,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] generate_out,
  output logic [LEN-1:0] propogate_out,
  output logic [LEN-1:0] half_sum_out,
  output logic           cin_out
);

  localparam int BW = 3 * LEN + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   head_q, head_d;
  logic [BW-1:0]   skid_q, skid_d;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [LEN-1:0]  b_eff;
  logic            cin_eff;
  logic [LEN-1:0]  half_sum;
  logic [LEN-1:0]  gen;
  logic [LEN-1:0]  prop;
  logic [BW-1:0]   beat;
  logic            accept;
  logic            pop;

  // Subtraction is A + ~B + 1; the carry-in is folded into bit 0 so the prefix tree sees no cin.
  always_comb begin
    b_eff    = sub ? ~b : b;
    cin_eff  = sub | cin;
    half_sum = a ^ b_eff;
    gen      = a & b_eff;
    gen[0]   = (a[0] & b_eff[0]) | (half_sum[0] & cin_eff);
    prop     = half_sum;
    prop[0]  = 1'b0;
    beat     = {gen, prop, half_sum, cin_eff};
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = beat;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = TWO;
          skid_d  = beat;
        end else if (pop && !accept) begin
          state_d = EMPTY;
        end else if (accept && pop) begin
          head_d = beat;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops the occupancy only; stale data stays in the registers.
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign generate_out  = head_q[BW-1 -: LEN];
  assign propogate_out = head_q[2*LEN -: LEN];
  assign half_sum_out  = head_q[LEN -: LEN];
  assign cin_out       = head_q[0];

endmodule

// File: tb/tb_adder_pg_stage.sv
// tb/tb_adder_pg_stage.sv - directed and table-driven bench for adder_pg_stage
module tb_adder_pg_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, sub, cin, out_valid, out_ready, cin_out;
  logic [31:0] a, b, generate_out, propogate_out, half_sum_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] hs;
    logic        c;
  } vec_t;

  vec_t vecs [8];

  adder_pg_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .generate_out(generate_out), .propogate_out(propogate_out),
    .half_sum_out(half_sum_out), .cin_out(cin_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [31:0] g, input logic [31:0] p,
                            input logic [31:0] hs, input logic c);
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".gen"}, generate_out, g);
    check({name, ".prop"}, propogate_out, p);
    check({name, ".half"}, half_sum_out, hs);
    check({name, ".cin"}, {31'd0, cin_out}, {31'd0, c});
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vs, input logic vc);
    in_valid = 1'b1;
    a = va; b = vb; sub = vs; cin = vc;
  endtask

  // Bit-serial reference: ripple through each position independently of the vector form.
  task automatic model(input logic [31:0] va, input logic [31:0] vb, input logic vs, input logic vc,
                       output logic [31:0] g, output logic [31:0] p, output logic [31:0] hs,
                       output logic c);
    logic be;
    c = vs ? 1'b1 : vc;
    for (int i = 0; i < 32; i++) begin
      be = vs ? !vb[i] : vb[i];
      hs[i] = va[i] != be;
      if (i == 0) begin
        g[i] = (va[i] && be) || (hs[i] && c);
        p[i] = 1'b0;
      end else begin
        g[i] = va[i] && be;
        p[i] = hs[i];
      end
    end
  endtask

  initial begin
    logic [31:0] eg, ep, eh;
    logic        ec;
    logic [31:0] ra, rb;
    logic        rs, rc;
    bit          ready_dropped;

    vecs[0] = '{32'h5, 32'h3, 1'b0, 1'b0, 32'h00000001, 32'h00000006, 32'h00000006, 1'b0};
    vecs[1] = '{32'h5, 32'h3, 1'b1, 1'b0, 32'h00000005, 32'hFFFFFFF8, 32'hFFFFFFF9, 1'b1};
    vecs[2] = '{32'h1, 32'h0, 1'b0, 1'b1, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{32'h0, 32'h0, 1'b1, 1'b0, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[7] = '{32'hF0F0F0F0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b1};

    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h12345678; b = 32'h9ABCDEF0; sub = 1'b0; cin = 1'b1;
    step(); step();
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.gen", generate_out, 32'd0);
    check("rst.prop", propogate_out, 32'd0);
    check("rst.half", half_sum_out, 32'd0);
    check("rst.cin", {31'd0, cin_out}, 32'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      step();
      in_valid = 1'b0;
      check_beat($sformatf("vec%0d", i), vecs[i].g, vecs[i].p, vecs[i].hs, vecs[i].c);
      step();
      check($sformatf("vec%0d.drain", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: two beats fill the buffer, third is held off then drains in order.
    out_ready = 1'b0;
    drive(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].cin);
    step();
    check("skid.b1.in_ready", {31'd0, in_ready}, 32'd1);
    check_beat("skid.b1", vecs[0].g, vecs[0].p, vecs[0].hs, vecs[0].c);
    drive(vecs[1].a, vecs[1].b, vecs[1].sub, vecs[1].cin);
    step();
    check("skid.b2.in_ready", {31'd0, in_ready}, 32'd0);
    check_beat("skid.hold1", vecs[0].g, vecs[0].p, vecs[0].hs, vecs[0].c);
    drive(vecs[2].a, vecs[2].b, vecs[2].sub, vecs[2].cin);
    step();
    check("skid.b3.in_ready", {31'd0, in_ready}, 32'd0);
    check_beat("skid.hold2", vecs[0].g, vecs[0].p, vecs[0].hs, vecs[0].c);
    out_ready = 1'b1;
    step();
    check_beat("skid.out2", vecs[1].g, vecs[1].p, vecs[1].hs, vecs[1].c);
    check("skid.reopen", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_beat("skid.out3", vecs[2].g, vecs[2].p, vecs[2].hs, vecs[2].c);
    step();
    check("skid.empty", {31'd0, out_valid}, 32'd0);

    // Reset from a full buffer.
    out_ready = 1'b0;
    drive(vecs[3].a, vecs[3].b, vecs[3].sub, vecs[3].cin);
    step();
    drive(vecs[4].a, vecs[4].b, vecs[4].sub, vecs[4].cin);
    step();
    check("two.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2.gen", generate_out, 32'd0);
    check("rst2.prop", propogate_out, 32'd0);
    check("rst2.half", half_sum_out, 32'd0);
    check("rst2.cin", {31'd0, cin_out}, 32'd0);
    out_ready = 1'b1;
    step();
    check("rst2.stays_empty", {31'd0, out_valid}, 32'd0);

    // Flush in ONE while a new beat is offered.
    out_ready = 1'b0;
    drive(vecs[5].a, vecs[5].b, vecs[5].sub, vecs[5].cin);
    step();
    check_beat("flush.pre", vecs[5].g, vecs[5].p, vecs[5].hs, vecs[5].c);
    drive(vecs[6].a, vecs[6].b, vecs[6].sub, vecs[6].cin);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush.out_valid", {31'd0, out_valid}, 32'd0);
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("flush.no_beat%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // Streaming at full rate.
    ready_dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom(); rb = $urandom();
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rs, rc);
      step();
      model(ra, rb, rs, rc, eg, ep, eh, ec);
      if (in_ready !== 1'b1) ready_dropped = 1'b1;
      check_beat($sformatf("stream%0d", i), eg, ep, eh, ec);
    end
    in_valid = 1'b0;
    check("stream.in_ready_held", {31'd0, ready_dropped}, 32'd0);
    step();
    check("stream.drain", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
